// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline boundary register with hold/flush control, stall timeout and illegal-control flag
// Optional PIPE_STAGE_PERF_EN adds free-running hold/flush/advance performance counters.
module pipe_stage_reg #(
    parameter int          DATA_W    = 64,
    parameter int          MAX_STALL = 15,
    parameter logic [31:0] NOP_WORD  = 32'h00000000
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [1:0]        Ctrl,
    input  logic [31:0]       In_Instruction,
    input  logic [DATA_W-1:0] In_Data,
    input  logic              In_Valid,
    output logic [31:0]       Out_Instruction,
    output logic [DATA_W-1:0] Out_Data,
    output logic              Out_Valid,
    output logic [1:0]        State,
    output logic              Stall_Timeout,
`ifdef PIPE_STAGE_PERF_EN
    output logic [31:0]       Perf_Hold_Cnt,
    output logic [31:0]       Perf_Flush_Cnt,
    output logic [31:0]       Perf_Adv_Cnt,
`endif
    output logic              Ctrl_Error
);

    localparam int CNT_W = $clog2(MAX_STALL + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STALL);

    localparam logic [1:0] CTRL_ADV  = 2'b00;
    localparam logic [1:0] CTRL_HOLD = 2'b01;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_HOLD   = 2'b01,
        ST_BUBBLE = 2'b10
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [31:0]         r_instr;
    logic [DATA_W-1:0]   r_data;
    logic                r_valid;
    logic [CNT_W-1:0]    r_hold_cnt;
    logic [CNT_W-1:0]    w_hold_cnt_nxt;
    logic                r_timeout;
    logic                r_ctrl_err;
    logic                w_is_adv;
    logic                w_is_hold;
    logic                w_is_flush;

    assign w_is_adv   = (Ctrl == CTRL_ADV);
    assign w_is_hold  = (Ctrl == CTRL_HOLD);
    // Illegal encoding 11 shares the flush path; only Ctrl_Error distinguishes it.
    assign w_is_flush = Ctrl[1];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_BUBBLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_is_flush) begin
            w_state_nxt = ST_BUBBLE;
        end else if (w_is_hold) begin
            w_state_nxt = r_valid ? ST_HOLD : ST_BUBBLE;
        end else begin
            w_state_nxt = In_Valid ? ST_RUN : ST_BUBBLE;
        end
    end

    always_comb begin
        State = r_state;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_instr <= NOP_WORD;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_is_flush) begin
            r_instr <= NOP_WORD;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_is_adv) begin
            r_instr <= In_Instruction;
            r_data  <= In_Data;
            r_valid <= In_Valid;
        end
    end

    always_comb begin
        w_hold_cnt_nxt = '0;
        if (w_is_hold) begin
            w_hold_cnt_nxt = (r_hold_cnt == CNT_MAX) ? r_hold_cnt : r_hold_cnt + 1'b1;
        end
    end

    // Timeout is registered alongside the counter so it rises with the MAX_STALL-th hold.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_hold_cnt <= w_hold_cnt_nxt;
            r_timeout  <= (w_hold_cnt_nxt == CNT_MAX);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_ctrl_err <= 1'b0;
        end else if (Ctrl == 2'b11) begin
            r_ctrl_err <= 1'b1;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] r_perf_hold;
    logic [31:0] r_perf_flush;
    logic [31:0] r_perf_adv;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_perf_hold  <= '0;
            r_perf_flush <= '0;
            r_perf_adv   <= '0;
        end else begin
            if (w_is_hold) begin
                r_perf_hold <= r_perf_hold + 32'd1;
            end
            if (w_is_flush) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
            if (w_is_adv && In_Valid) begin
                r_perf_adv <= r_perf_adv + 32'd1;
            end
        end
    end

    assign Perf_Hold_Cnt  = r_perf_hold;
    assign Perf_Flush_Cnt = r_perf_flush;
    assign Perf_Adv_Cnt   = r_perf_adv;
`endif

    assign Out_Instruction = r_instr;
    assign Out_Data        = r_data;
    assign Out_Valid       = r_valid;
    assign Stall_Timeout   = r_timeout;
    assign Ctrl_Error      = r_ctrl_err;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg against a behavioural model
module tb_pipe_stage_reg;

    localparam int          DATA_W    = 64;
    localparam int          MAX_STALL = 4;
    localparam logic [31:0] NOP       = 32'h00000000;
    localparam logic [1:0]  S_RUN     = 2'b00;
    localparam logic [1:0]  S_HOLD    = 2'b01;
    localparam logic [1:0]  S_BUBBLE  = 2'b10;

    logic              Clk = 1'b0;
    logic              Reset_n = 1'b0;
    logic [1:0]        Ctrl = 2'b00;
    logic [31:0]       In_Instruction = '0;
    logic [DATA_W-1:0] In_Data = '0;
    logic              In_Valid = 1'b0;
    logic [31:0]       Out_Instruction;
    logic [DATA_W-1:0] Out_Data;
    logic              Out_Valid;
    logic [1:0]        State;
    logic              Stall_Timeout;
    logic              Ctrl_Error;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]       Perf_Hold_Cnt;
    logic [31:0]       Perf_Flush_Cnt;
    logic [31:0]       Perf_Adv_Cnt;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model: architectural view of the stage.
    logic [31:0]       m_instr;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic [1:0]        m_state;
    int                m_consec_holds;
    logic              m_err;
    int unsigned       m_hold_total;
    int unsigned       m_flush_total;
    int unsigned       m_adv_total;

    pipe_stage_reg #(.DATA_W(DATA_W), .MAX_STALL(MAX_STALL), .NOP_WORD(NOP)) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .Ctrl(Ctrl),
        .In_Instruction(In_Instruction),
        .In_Data(In_Data),
        .In_Valid(In_Valid),
        .Out_Instruction(Out_Instruction),
        .Out_Data(Out_Data),
        .Out_Valid(Out_Valid),
        .State(State),
        .Stall_Timeout(Stall_Timeout),
`ifdef PIPE_STAGE_PERF_EN
        .Perf_Hold_Cnt(Perf_Hold_Cnt),
        .Perf_Flush_Cnt(Perf_Flush_Cnt),
        .Perf_Adv_Cnt(Perf_Adv_Cnt),
`endif
        .Ctrl_Error(Ctrl_Error)
    );

    always #5 Clk = ~Clk;

    task automatic model_reset();
        m_instr = NOP;
        m_data = '0;
        m_valid = 1'b0;
        m_state = S_BUBBLE;
        m_consec_holds = 0;
        m_err = 1'b0;
        m_hold_total = 0;
        m_flush_total = 0;
        m_adv_total = 0;
    endtask

    task automatic model_step(input logic [1:0] c, input logic [31:0] ins,
                              input logic [DATA_W-1:0] d, input logic v);
        if (c == 2'b00) begin
            m_instr = ins;
            m_data = d;
            m_valid = v;
            m_state = v ? S_RUN : S_BUBBLE;
            m_consec_holds = 0;
            if (v) m_adv_total++;
        end else if (c == 2'b01) begin
            m_state = m_valid ? S_HOLD : S_BUBBLE;
            m_consec_holds++;
            m_hold_total++;
        end else begin
            m_instr = NOP;
            m_data = '0;
            m_valid = 1'b0;
            m_state = S_BUBBLE;
            m_consec_holds = 0;
            m_flush_total++;
            if (c == 2'b11) m_err = 1'b1;
        end
    endtask

    // One clock: drive inputs, take the edge, advance the model, land 1ns after the edge.
    task automatic drive_cycle(input logic [1:0] c, input logic [31:0] ins,
                               input logic [DATA_W-1:0] d, input logic v);
        Ctrl = c;
        In_Instruction = ins;
        In_Data = d;
        In_Valid = v;
        @(posedge Clk);
        model_step(c, ins, d, v);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        return {$urandom, $urandom};
    endfunction

    task automatic test_reset();
        Reset_n = 1'b0;
        Ctrl = 2'b00;
        In_Valid = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        model_reset();
        checks++; if (Out_Instruction !== NOP) begin failures++; $display("FAIL reset_instr got=%h exp=%h", Out_Instruction, NOP); end
        checks++; if (Out_Data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", Out_Data); end
        checks++; if (Out_Valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", Out_Valid); end
        checks++; if (State !== S_BUBBLE) begin failures++; $display("FAIL reset_state got=%b exp=%b", State, S_BUBBLE); end
        checks++; if (Stall_Timeout !== 1'b0 || Ctrl_Error !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", Stall_Timeout, Ctrl_Error); end
        Reset_n = 1'b1;
    endtask

    task automatic test_advance_hold();
        logic [DATA_W-1:0] d;
        d = rand_data();
        drive_cycle(2'b00, 32'h8C220004, d, 1'b1);
        checks++; if (Out_Instruction !== 32'h8C220004) begin failures++; $display("FAIL adv_instr got=%h exp=8c220004", Out_Instruction); end
        checks++; if (Out_Data !== d) begin failures++; $display("FAIL adv_data got=%h exp=%h", Out_Data, d); end
        checks++; if (Out_Valid !== 1'b1 || State !== S_RUN) begin failures++; $display("FAIL adv_state got=%b/%b exp=1/%b", Out_Valid, State, S_RUN); end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(2'b01, 32'h00430820, rand_data(), 1'b1);
            checks++; if (Out_Instruction !== 32'h8C220004) begin failures++; $display("FAIL hold_instr[%0d] got=%h exp=8c220004", i, Out_Instruction); end
            checks++; if (State !== S_HOLD) begin failures++; $display("FAIL hold_state[%0d] got=%b exp=%b", i, State, S_HOLD); end
            checks++; if (Stall_Timeout !== 1'b0) begin failures++; $display("FAIL hold_timeout[%0d] got=%b exp=0", i, Stall_Timeout); end
        end
    endtask

    task automatic test_flush();
        drive_cycle(2'b10, 32'h12345678, rand_data(), 1'b1);
        checks++; if (Out_Instruction !== NOP || Out_Data !== '0) begin failures++; $display("FAIL flush_payload got=%h/%h exp=%h/0", Out_Instruction, Out_Data, NOP); end
        checks++; if (Out_Valid !== 1'b0 || State !== S_BUBBLE) begin failures++; $display("FAIL flush_state got=%b/%b exp=0/%b", Out_Valid, State, S_BUBBLE); end
        drive_cycle(2'b01, 32'h87654321, rand_data(), 1'b1);
        checks++; if (State !== S_BUBBLE || Out_Valid !== 1'b0) begin failures++; $display("FAIL held_bubble got=%b/%b exp=%b/0", State, Out_Valid, S_BUBBLE); end
    endtask

    task automatic test_timeout();
        drive_cycle(2'b00, 32'hAABBCCDD, rand_data(), 1'b1);
        for (int i = 1; i <= 6; i++) begin
            drive_cycle(2'b01, $urandom, rand_data(), 1'b1);
            checks++; if (Stall_Timeout !== (i >= MAX_STALL)) begin failures++; $display("FAIL timeout_hold[%0d] got=%b exp=%b", i, Stall_Timeout, (i >= MAX_STALL)); end
        end
        drive_cycle(2'b00, 32'h11112222, rand_data(), 1'b1);
        checks++; if (Stall_Timeout !== 1'b0) begin failures++; $display("FAIL timeout_drop got=%b exp=0", Stall_Timeout); end
        checks++; if (State !== S_RUN || Out_Instruction !== 32'h11112222) begin failures++; $display("FAIL timeout_resume got=%b/%h exp=%b/11112222", State, Out_Instruction, S_RUN); end
    endtask

    task automatic test_illegal_reset();
        drive_cycle(2'b00, 32'hDEADBEEF, rand_data(), 1'b1);
        drive_cycle(2'b11, 32'hCAFEF00D, rand_data(), 1'b1);
        checks++; if (Out_Instruction !== NOP || Out_Valid !== 1'b0 || State !== S_BUBBLE) begin failures++; $display("FAIL illegal_flush got=%h/%b/%b exp=%h/0/%b", Out_Instruction, Out_Valid, State, NOP, S_BUBBLE); end
        checks++; if (Ctrl_Error !== 1'b1) begin failures++; $display("FAIL illegal_err got=%b exp=1", Ctrl_Error); end
        drive_cycle(2'b00, 32'h0BADC0DE, rand_data(), 1'b1);
        checks++; if (Ctrl_Error !== 1'b1 || Out_Instruction !== 32'h0BADC0DE) begin failures++; $display("FAIL illegal_sticky got=%b/%h exp=1/0badc0de", Ctrl_Error, Out_Instruction); end
        drive_cycle(2'b01, 32'h0, rand_data(), 1'b1);
        #3;
        Reset_n = 1'b0;
        #1;
        model_reset();
        checks++; if (Ctrl_Error !== 1'b0) begin failures++; $display("FAIL async_reset_err got=%b exp=0", Ctrl_Error); end
        checks++; if (Out_Valid !== 1'b0 || State !== S_BUBBLE || Out_Instruction !== NOP) begin failures++; $display("FAIL async_reset_state got=%b/%b/%h exp=0/%b/%h", Out_Valid, State, Out_Instruction, S_BUBBLE, NOP); end
        Reset_n = 1'b1;
        drive_cycle(2'b00, 32'h01020304, rand_data(), 1'b1);
        checks++; if (State !== S_RUN || Out_Instruction !== 32'h01020304) begin failures++; $display("FAIL post_reset_adv got=%b/%h exp=%b/01020304", State, Out_Instruction, S_RUN); end
    endtask

    task automatic test_random();
        logic [1:0] c;
        int r;
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 19);
            c = (r < 8) ? 2'b00 : (r < 17) ? 2'b01 : (r < 19) ? 2'b10 : 2'b11;
            drive_cycle(c, $urandom, rand_data(), 1'($urandom_range(0, 3) != 0));
            checks++;
            if (Out_Instruction !== m_instr || Out_Data !== m_data || Out_Valid !== m_valid ||
                State !== m_state || Stall_Timeout !== (m_consec_holds >= MAX_STALL) || Ctrl_Error !== m_err) begin
                failures++;
                $display("FAIL random[%0d] got=%h/%h/%b/%b/%b/%b exp=%h/%h/%b/%b/%b/%b", n,
                         Out_Instruction, Out_Data, Out_Valid, State, Stall_Timeout, Ctrl_Error,
                         m_instr, m_data, m_valid, m_state, (m_consec_holds >= MAX_STALL), m_err);
            end
`ifdef PIPE_STAGE_PERF_EN
            checks++;
            if (Perf_Hold_Cnt !== m_hold_total || Perf_Flush_Cnt !== m_flush_total || Perf_Adv_Cnt !== m_adv_total) begin
                failures++;
                $display("FAIL random_perf[%0d] got=%0d/%0d/%0d exp=%0d/%0d/%0d", n, Perf_Hold_Cnt, Perf_Flush_Cnt,
                         Perf_Adv_Cnt, m_hold_total, m_flush_total, m_adv_total);
            end
`endif
        end
    endtask

`ifdef PIPE_STAGE_PERF_EN
    task automatic test_perf();
        logic [1:0] seq [6];
        seq = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10};
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        model_reset();
        Reset_n = 1'b1;
        foreach (seq[i]) drive_cycle(seq[i], $urandom, rand_data(), 1'b1);
        checks++; if (Perf_Adv_Cnt !== 32'd2) begin failures++; $display("FAIL perf_adv got=%0d exp=2", Perf_Adv_Cnt); end
        checks++; if (Perf_Hold_Cnt !== 32'd3) begin failures++; $display("FAIL perf_hold got=%0d exp=3", Perf_Hold_Cnt); end
        checks++; if (Perf_Flush_Cnt !== 32'd1) begin failures++; $display("FAIL perf_flush got=%0d exp=1", Perf_Flush_Cnt); end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_advance_hold();
        test_flush();
        test_timeout();
        test_illegal_reset();
        test_random();
`ifdef PIPE_STAGE_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
